cube_color_ctrl: RTL
====================

Name: cube_color_ctrl

Overview:
- Game-side controller that owns the per-cube top-colour vector driving e_color_state of the map colour datapath.
- Watches Q*bert landing events (done_move rising edge plus the one-hot position_qb hitbox vector) and recolours the landed cube.
- Counts coloured cubes and flags level completion.
- Sits between qbert_layer/position logic and the map renderer; the NIOS only starts, pauses and reads status.

Parameters:
- N_CUBE, 28, number of cubes in the pyramid; width of pos_in and color_state.
- CNT_W, 5, width of the coloured-cube counter; must satisfy 2**CNT_W > N_CUBE.

Ports:
- CLK_33  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level start/restart; single-cycle pulse, may also be held.
- pause  input  1  level-sensitive pause; landing events are dropped while high.
- done_move  input  1  move-complete from the Q*bert layer; only its rising edge counts.
- pos_in  input  N_CUBE  cube hitbox vector (position_qb); expected one-hot or zero.
- color_state  output  N_CUBE  bit i = 1 means cube i shows its target colour; feeds e_color_state.
- cubes_done  output  CNT_W  number of set bits in color_state.
- score_inc  output  1  one-cycle pulse when a cube newly changes colour.
- off_map  output  1  one-cycle pulse when a landing has pos_in == 0.
- pos_err  output  1  one-cycle pulse when a landing has more than one pos_in bit set.
- level_done  output  1  high while in WIN.
- ctrl_state  output  2  FSM encoding: IDLE=0, PLAY=1, CHECK=2, WIN=3.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0 and ctrl_state=IDLE. Internal done_move_q=0 and pos_q=0. Reset asserted mid-CHECK aborts the update; no partial colour change is visible.
- Edge detect: done_move_q registers done_move every cycle. A landing is the condition done_move & ~done_move_q at a clock edge.
- start has priority over everything. When start=1 at a clock edge, in any state:
  - color_state and cubes_done clear to 0.
  - score_inc, off_map and pos_err are 0.
  - Next state is PLAY.
  - A landing on the same edge is discarded.
- IDLE: ignore landings. Leave only on start.
- PLAY:
  - A landing at edge k with pause=0 latches pos_in into pos_q and moves to CHECK.
  - A landing with pause=1 is dropped. It is not replayed after pause falls, because done_move_q keeps tracking.
- CHECK (edge k+1), exactly one cycle:
  - pos_q one-hot, bit i already 0: set color_state[i], increment cubes_done, pulse score_inc.
  - pos_q one-hot, bit i already 1: no change, no pulse.
  - pos_q == 0: no change, pulse off_map.
  - popcount(pos_q) > 1: no change, pulse pos_err.
  - Next state is WIN if the post-update count equals N_CUBE, otherwise PLAY.
  - A new done_move edge arriving during CHECK is dropped.
- WIN: level_done=1, color_state frozen, landings ignored. Leave only on start.
- Latency: a landing at edge k makes color_state, cubes_done, score_inc and level_done visible after edge k+1. The pulse outputs are registered and last exactly one cycle.
- Arithmetic: cubes_done never exceeds N_CUBE and never underflows. One-hot detection uses a popcount or the (x & (x-1)) == 0 test on N_CUBE bits.

Optional Feature:
- Macro: CUBE_COLOR_TOGGLE_EN.
- Defined: in CHECK, a one-hot landing on a cube whose bit is already 1 clears that bit and decrements cubes_done; score_inc stays 0. WIN is still entered only when the count reaches N_CUBE.
- Undefined: landing on an already-coloured cube leaves the state unchanged, as specified above.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, ctrl_state=0. Release, then pulse start -> ctrl_state=1 on the next cycle.
- Single landing: PLAY, pos_in=28'h0000004, done_move 0->1 -> after 2 edges color_state=28'h0000004, cubes_done=1, score_inc high for exactly 1 cycle. Repeat the same landing -> no change, score_inc=0 (toggle build: color_state=0, cubes_done=0).
- Error cases: landing with pos_in=0 -> off_map pulse, state unchanged. Landing with pos_in=28'h0000003 -> pos_err pulse, state unchanged.
- Win: 28 distinct one-hot landings -> after the last, cubes_done=28, color_state=28'hFFFFFFF, level_done=1, ctrl_state=3. A further landing changes nothing.
- Pause: pause=1 during a done_move edge -> no update. Drop pause while done_move stays high -> still no update. A new edge after pause=0 -> update occurs.
- Restart priority: start and a landing on the same edge with cubes_done=5 -> color_state=0, cubes_done=0, no score_inc, ctrl_state=PLAY. Reset asserted during CHECK -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cube_color_ctrl.sv
// cube_color_ctrl
//   Owns the per-cube top-colour vector that feeds e_color_state of the map
//   colour datapath. A Q*bert landing (rising edge of done_move) latches the
//   hitbox vector, and the following CHECK cycle recolours the landed cube.
//   The block also counts coloured cubes and flags level completion.
//
//   Optional feature macro: CUBE_COLOR_TOGGLE_EN
//     When it is defined, landing on an already-coloured cube reverts that
//     cube and decrements the count.
//     When it is undefined, landing on an already-coloured cube changes
//     nothing.
//
//   ctrl_state encoding: IDLE=0, PLAY=1, CHECK=2, WIN=3.

module cube_color_ctrl #(
  parameter int N_CUBE = 28,
  parameter int CNT_W  = 5
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              done_move,
  input  logic [N_CUBE-1:0] pos_in,
  output logic [N_CUBE-1:0] color_state,
  output logic [CNT_W-1:0]  cubes_done,
  output logic              score_inc,
  output logic              off_map,
  output logic              pos_err,
  output logic              level_done,
  output logic [1:0]        ctrl_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    WIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CUBE);

  state_t              state_reg,        state_next;
  logic                done_move_q_reg;
  logic [N_CUBE-1:0]   pos_q_reg,        pos_q_next;
  logic [N_CUBE-1:0]   color_state_reg,  color_state_next;
  logic [CNT_W-1:0]    cubes_done_reg,   cubes_done_next;
  logic                score_inc_reg,    score_inc_next;
  logic                off_map_reg,      off_map_next;
  logic                pos_err_reg,      pos_err_next;

  logic                landing;
  logic                pos_zero;
  logic                pos_multi;
  logic                hit_colored;
  logic [N_CUBE-1:0]   color_upd;

  // Classify the latched hitbox vector and detect the done_move rising edge.
  always_comb begin
    landing     = done_move & ~done_move_q_reg;
    pos_zero    = (pos_q_reg == '0);
    pos_multi   = !pos_zero && ((pos_q_reg & (pos_q_reg - N_CUBE'(1))) != '0);
    hit_colored = |(color_state_reg & pos_q_reg);
  end

  // Per-cube candidate colour for a one-hot landing. Bits that pos_q does
  // not select keep their value, so this is used only for a one-hot pos_q.
  generate
    for (genvar gi = 0; gi < N_CUBE; gi++) begin : g_cube
`ifdef CUBE_COLOR_TOGGLE_EN
      assign color_upd[gi] = color_state_reg[gi] ^ pos_q_reg[gi];
`else
      assign color_upd[gi] = color_state_reg[gi] | pos_q_reg[gi];
`endif
    end
  endgenerate

  // Next-state, colour update and pulse generation. start overrides every state.
  always_comb begin
    state_next       = state_reg;
    pos_q_next       = pos_q_reg;
    color_state_next = color_state_reg;
    cubes_done_next  = cubes_done_reg;
    score_inc_next   = 1'b0;
    off_map_next     = 1'b0;
    pos_err_next     = 1'b0;

    if (start) begin
      state_next       = PLAY;
      color_state_next = '0;
      cubes_done_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end

        PLAY: begin
          // A paused landing is lost for good: done_move_q keeps tracking.
          if (landing && !pause) begin
            pos_q_next = pos_in;
            state_next = CHECK;
          end
        end

        CHECK: begin
          if (pos_zero) begin
            off_map_next = 1'b1;
          end else if (pos_multi) begin
            pos_err_next = 1'b1;
          end else if (!hit_colored) begin
            color_state_next = color_upd;
            score_inc_next   = 1'b1;
            if (cubes_done_reg < CNT_FULL) begin
              cubes_done_next = cubes_done_reg + CNT_W'(1);
            end
          end else begin
`ifdef CUBE_COLOR_TOGGLE_EN
            color_state_next = color_upd;
            if (cubes_done_reg != '0) begin
              cubes_done_next = cubes_done_reg - CNT_W'(1);
            end
`else
            color_state_next = color_state_reg;
`endif
          end
          state_next = (cubes_done_next == CNT_FULL) ? WIN : PLAY;
        end

        WIN: begin
          state_next = WIN;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, colour vector, counter and registered pulses. Reset is asynchronous.
  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      done_move_q_reg <= 1'b0;
      pos_q_reg       <= '0;
      color_state_reg <= '0;
      cubes_done_reg  <= '0;
      score_inc_reg   <= 1'b0;
      off_map_reg     <= 1'b0;
      pos_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      done_move_q_reg <= done_move;
      pos_q_reg       <= pos_q_next;
      color_state_reg <= color_state_next;
      cubes_done_reg  <= cubes_done_next;
      score_inc_reg   <= score_inc_next;
      off_map_reg     <= off_map_next;
      pos_err_reg     <= pos_err_next;
    end
  end

  assign color_state = color_state_reg;
  assign cubes_done  = cubes_done_reg;
  assign score_inc   = score_inc_reg;
  assign off_map     = off_map_reg;
  assign pos_err     = pos_err_reg;
  assign level_done  = (state_reg == WIN);
  assign ctrl_state  = state_reg;

endmodule
